sr_req_conditioner: RTL and testbench

- Upstream stage for the team's SR flip-flop.
- Takes raw, asynchronous set/clear request lines (buttons, external strobes), then synchronizes, debounces and edge-detects them.
- Arbitrates the requests and drives single-cycle S/R pulses, so the flop never sees S and R high together.
- Watches the flop's Q output to confirm each command landed, and flags an error if it did not.

---
 rtl/sr_req_conditioner.sv | 178 +++++++++++++++++
 tb/tb_sr_req_conditioner.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_req_conditioner.sv
// Synchronizes, debounces and arbitrates raw set/clear requests into guarded S/R pulses,
// then confirms each command on q_fb. Define SR_REQ_COND_TOGGLE_EN to add a toggle channel.
module sr_req_conditioner #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CONFIRM_TIMEOUT = 8,
   parameter int CLR_PRIORITY    = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic set_req_raw,
   input  logic clr_req_raw,
`ifdef SR_REQ_COND_TOGGLE_EN
   input  logic tog_req_raw,
`endif
   input  logic q_fb,
   input  logic err_clr,
   output logic s_out,
   output logic r_out,
   output logic done,
   output logic err,
   output logic busy
);

`ifdef SR_REQ_COND_TOGGLE_EN
   localparam int NCH    = 3;
   localparam int CH_TOG = 2;
`else
   localparam int NCH    = 2;
`endif
   localparam int CH_SET = 0;
   localparam int CH_CLR = 1;
   localparam int CW     = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
   localparam int TW     = (CONFIRM_TIMEOUT < 2) ? 1 : $clog2(CONFIRM_TIMEOUT);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ERR} state_t;

   logic [NCH-1:0]         raw;
   logic [SYNC_STAGES-1:0] sync_p0 [NCH];
   logic [NCH-1:0]         sync_q;
   logic [CW-1:0]          deb_cnt [NCH];
   logic [NCH-1:0]         deb_p1;
   logic [NCH-1:0]         deb_p2;
   logic [NCH-1:0]         rise;
   logic [NCH-1:0]         pend;
   logic [NCH-1:0]         svc_drop;
   logic                   svc_go;
   logic                   svc_tgt;
   state_t                 state;
   logic                   tgt;
   logic [TW-1:0]          tmo;

`ifdef SR_REQ_COND_TOGGLE_EN
   assign raw = {tog_req_raw, clr_req_raw, set_req_raw};
`else
   assign raw = {clr_req_raw, set_req_raw};
`endif

   // Stage 0: metastability synchronizers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int ch = 0; ch < NCH; ch++) sync_p0[ch] <= '0;
      end else begin
         for (int ch = 0; ch < NCH; ch++)
            sync_p0[ch] <= {sync_p0[ch][SYNC_STAGES-2:0], raw[ch]};
      end
   end

   always_comb begin
      for (int ch = 0; ch < NCH; ch++) sync_q[ch] = sync_p0[ch][SYNC_STAGES-1];
   end

   // Stage 1: debounce; a level must persist DEBOUNCE_CYCLES edges before it is taken
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_p1 <= '0;
         deb_p2 <= '0;
         for (int ch = 0; ch < NCH; ch++) deb_cnt[ch] <= '0;
      end else begin
         deb_p2 <= deb_p1;
         for (int ch = 0; ch < NCH; ch++) begin
            if (sync_q[ch] != deb_p1[ch]) begin
               if (deb_cnt[ch] == CW'(DEBOUNCE_CYCLES - 1)) begin
                  deb_p1[ch]  <= sync_q[ch];
                  deb_cnt[ch] <= '0;
               end else begin
                  deb_cnt[ch] <= deb_cnt[ch] + 1'b1;
               end
            end else begin
               deb_cnt[ch] <= '0;
            end
         end
      end
   end

   // Stage 2: rising edges of the debounced level become pending requests
   assign rise = deb_p1 & ~deb_p2;

   // Arbitration: set/clear dominate, a toggle alongside them is discarded
   always_comb begin
      svc_go   = 1'b0;
      svc_tgt  = 1'b0;
      svc_drop = '0;
      if (pend[CH_SET] && pend[CH_CLR]) begin
         svc_go   = 1'b1;
         svc_tgt  = (CLR_PRIORITY == 0);
         svc_drop = '1;
      end else if (pend[CH_SET] || pend[CH_CLR]) begin
         svc_tgt  = pend[CH_SET];
         svc_go   = (q_fb != pend[CH_SET]);
         svc_drop = '1;
      end
`ifdef SR_REQ_COND_TOGGLE_EN
      else if (pend[CH_TOG]) begin
         svc_go           = 1'b1;
         svc_tgt          = ~q_fb;
         svc_drop[CH_TOG] = 1'b1;
      end
`endif
   end

   // Stage 3: command sequencer with registered pulse and status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         pend  <= '0;
         tgt   <= 1'b0;
         tmo   <= '0;
         s_out <= 1'b0;
         r_out <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
         busy  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) pend <= (pend & ~svc_drop) | rise;
         else               pend <= pend | rise;
         case (state)
            IDLE: begin
               if (svc_go) begin
                  tgt   <= svc_tgt;
                  s_out <= svc_tgt;
                  r_out <= ~svc_tgt;
                  busy  <= 1'b1;
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               s_out <= 1'b0;
               r_out <= 1'b0;
               tmo   <= '0;
               state <= WAIT;
            end
            WAIT: begin
               if (q_fb == tgt) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else if (tmo == TW'(CONFIRM_TIMEOUT - 1)) begin
                  err   <= 1'b1;
                  state <= ERR;
               end else begin
                  tmo <= tmo + 1'b1;
               end
            end
            ERR: begin
               if (err_clr) begin
                  err   <= 1'b0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sr_req_conditioner.sv
// Bench for sr_req_conditioner: table of raw-input waveforms with expected pulse events,
// checked through per-instance scoreboard queues, plus an asynchronous-reset sequence.
module tb_sr_req_conditioner;

   localparam logic [2:0] K_S = 3'd1;
   localparam logic [2:0] K_R = 3'd2;
   localparam logic [2:0] K_D = 3'd3;
   localparam logic [2:0] K_E = 3'd4;

   typedef struct packed {
      logic [2:0] k;
      logic [5:0] t;
   } exp_t;

   typedef struct packed {
      logic        inst;
      logic        q0;
      logic        fen;
      logic [31:0] set_p;
      logic [31:0] clr_p;
      logic [31:0] tog_p;
      logic [31:0] eclr_p;
      exp_t [3:0]  evs;
   } row_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] set_raw, clr_raw, eclr, q_fb, q_load, q_val, fen;
`ifdef SR_REQ_COND_TOGGLE_EN
   logic [1:0] tog_raw;
`endif
   logic [1:0] s_out, r_out, done, err, busy;
   int         edge_n = 0;
   int         base_edge = 0;
   int         n_vec = 0;
   int         n_miss = 0;
   exp_t       exp_a[$];
   exp_t       exp_b[$];
   row_t       rows[$];

   always #5 clk = ~clk;
   always @(posedge clk) edge_n <= edge_n + 1;

   // Behavioural SR flop closing the q_fb loop for each instance
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (q_load[i])      q_fb[i] <= q_val[i];
         else if (fen[i]) begin
            if (s_out[i])      q_fb[i] <= 1'b1;
            else if (r_out[i]) q_fb[i] <= 1'b0;
         end
      end
   end

   sr_req_conditioner #(.CLR_PRIORITY(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .set_req_raw(set_raw[0]), .clr_req_raw(clr_raw[0]),
`ifdef SR_REQ_COND_TOGGLE_EN
      .tog_req_raw(tog_raw[0]),
`endif
      .q_fb(q_fb[0]), .err_clr(eclr[0]), .s_out(s_out[0]), .r_out(r_out[0]),
      .done(done[0]), .err(err[0]), .busy(busy[0]));

   sr_req_conditioner #(.CLR_PRIORITY(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .set_req_raw(set_raw[1]), .clr_req_raw(clr_raw[1]),
`ifdef SR_REQ_COND_TOGGLE_EN
      .tog_req_raw(tog_raw[1]),
`endif
      .q_fb(q_fb[1]), .err_clr(eclr[1]), .s_out(s_out[1]), .r_out(r_out[1]),
      .done(done[1]), .err(err[1]), .busy(busy[1]));

   function automatic exp_t ev(input logic [2:0] k, input int t);
      exp_t e;
      e.k = k;
      e.t = 6'(t);
      return e;
   endfunction

   function automatic row_t mk_row(input logic inst, input logic q0, input logic fen_v,
                                   input logic [31:0] sp, input logic [31:0] cp,
                                   input logic [31:0] tp, input logic [31:0] ep,
                                   input exp_t e0, input exp_t e1, input exp_t e2, input exp_t e3);
      row_t r;
      r.inst = inst;  r.q0 = q0;  r.fen = fen_v;
      r.set_p = sp;   r.clr_p = cp;  r.tog_p = tp;  r.eclr_p = ep;
      r.evs[0] = e0;  r.evs[1] = e1;  r.evs[2] = e2;  r.evs[3] = e3;
      return r;
   endfunction

   task automatic check(input string name, input int got, input int want);
      n_vec++;
      if (got != want) begin
         n_miss++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   task automatic got_event(input int i, input logic [2:0] k);
      exp_t e;
      int   rel;
      logic have;
      rel  = edge_n - base_edge;
      have = (i == 0) ? (exp_a.size() != 0) : (exp_b.size() != 0);
      n_vec++;
      if (!have) begin
         n_miss++;
         $display("FAIL event_unexpected inst=%0d: got kind=%0d at edge %0d, want none", i, k, rel);
      end else begin
         if (i == 0) e = exp_a.pop_front();
         else        e = exp_b.pop_front();
         if (e.k != k || int'(e.t) != rel) begin
            n_miss++;
            $display("FAIL event inst=%0d: got kind=%0d at edge %0d, want kind=%0d at edge %0d",
                     i, k, rel, e.k, e.t);
         end
      end
   endtask

   task automatic monitor();
      logic [1:0] err_q = '0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (s_out[i] || r_out[i]) check("s_and_r_exclusive", int'(s_out[i] & r_out[i]), 0);
            if (s_out[i]) got_event(i, K_S);
            if (r_out[i]) got_event(i, K_R);
            if (done[i])  got_event(i, K_D);
            if (err[i] && !err_q[i]) got_event(i, K_E);
         end
         err_q = err;
      end
   endtask

   task automatic drive(input int inst, input logic s, input logic c, input logic e);
      set_raw = '0;  clr_raw = '0;  eclr = '0;
      set_raw[inst] = s;  clr_raw[inst] = c;  eclr[inst] = e;
   endtask

`ifdef SR_REQ_COND_TOGGLE_EN
   task automatic drive_tog(input int inst, input logic t);
      tog_raw = '0;
      tog_raw[inst] = t;
   endtask
`endif

   task automatic push_exp(input int inst, input exp_t e);
      if (inst == 0) exp_a.push_back(e);
      else           exp_b.push_back(e);
   endtask

   task automatic row_end();
      check("missing_events_a", exp_a.size(), 0);
      check("missing_events_b", exp_b.size(), 0);
      exp_a.delete();
      exp_b.delete();
      check("err_busy_idle", int'({err, busy}), 0);
   endtask

   task automatic run_row(input row_t r);
      int inst;
      inst = int'(r.inst);
      @(negedge clk);
      rst_n = 1'b0;
      drive(0, 1'b0, 1'b0, 1'b0);
`ifdef SR_REQ_COND_TOGGLE_EN
      drive_tog(0, 1'b0);
`endif
      q_load = '1;
      q_val = '0;  q_val[inst] = r.q0;
      fen = '0;    fen[inst] = r.fen;
      @(negedge clk);
      check("reset_outputs", int'({s_out, r_out, done, err, busy}), 0);
      q_load = '0;
      rst_n = 1'b1;
      base_edge = edge_n;
      for (int j = 0; j < 4; j++) if (r.evs[j].k != 3'd0) push_exp(inst, r.evs[j]);
      for (int c = 0; c < 44; c++) begin
         int b;
         b = (c > 31) ? 31 : c;
         if (c > 0) @(negedge clk);
         drive(inst, r.set_p[b], r.clr_p[b], r.eclr_p[b]);
`ifdef SR_REQ_COND_TOGGLE_EN
         drive_tog(inst, r.tog_p[b]);
`endif
      end
      @(negedge clk);
      row_end();
   endtask

   initial begin
      exp_t none;
      none = ev(3'd0, 0);
      rst_n = 1'b0;
      set_raw = '0;  clr_raw = '0;  eclr = '0;
      q_load = '1;   q_val = '0;    fen = '0;
`ifdef SR_REQ_COND_TOGGLE_EN
      tog_raw = '0;
`endif
      fork
         monitor();
      join_none

      // stable set, flop follows: S after edge 8, done two edges later
      rows.push_back(mk_row(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0,
                            ev(K_S, 8), ev(K_D, 10), none, none));
      // bouncy clear: high 2, low 1, then high
      rows.push_back(mk_row(1'b0, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFB, 32'h0, 32'h0,
                            ev(K_R, 11), ev(K_D, 13), none, none));
      // simultaneous set and clear, clear priority
      rows.push_back(mk_row(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0,
                            ev(K_R, 8), ev(K_D, 10), none, none));
      // simultaneous set and clear, set priority instance
      rows.push_back(mk_row(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0,
                            ev(K_S, 8), ev(K_D, 10), none, none));
      // stuck flop: timeout, clear held in ERR, err_clr, clear then redundant
      rows.push_back(mk_row(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_F000, 32'h0, 32'h0040_0000,
                            ev(K_S, 8), ev(K_E, 17), none, none));
      // clear rises while the set command is still in flight
      rows.push_back(mk_row(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0, 32'h0,
                            ev(K_S, 8), ev(K_D, 10), ev(K_R, 11), ev(K_D, 13)));
      // falling edge of set is ignored
      rows.push_back(mk_row(1'b0, 1'b0, 1'b1, 32'h0000_0FFF, 32'h0, 32'h0, 32'h0,
                            ev(K_S, 8), ev(K_D, 10), none, none));
      // clear with q_fb already 0 is dropped
      rows.push_back(mk_row(1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0,
                            none, none, none, none));
`ifdef SR_REQ_COND_TOGGLE_EN
      // toggle from q=1 clears, second toggle from q=0 sets
      rows.push_back(mk_row(1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 32'hFFF0_0FFF, 32'h0,
                            ev(K_R, 8), ev(K_D, 10), ev(K_S, 28), ev(K_D, 30)));
`endif

      foreach (rows[i]) run_row(rows[i]);

      // asynchronous reset in WAIT, then a fresh set after release
      @(negedge clk);
      rst_n = 1'b0;
      drive(0, 1'b0, 1'b0, 1'b0);
      q_load = 2'b01;  q_val = '0;  fen = '0;
      @(negedge clk);
      q_load = '0;
      rst_n = 1'b1;
      base_edge = edge_n;
      exp_a.push_back(ev(K_S, 8));
      drive(0, 1'b1, 1'b0, 1'b0);
      repeat (12) @(negedge clk);
      check("busy_in_wait", int'(busy[0]), 1);
      #2 rst_n = 1'b0;
      #1 check("async_reset_outputs", int'({s_out[0], r_out[0], done[0], err[0], busy[0]}), 0);
      @(negedge clk);
      fen = 2'b01;
      rst_n = 1'b1;
      base_edge = edge_n;
      exp_a.push_back(ev(K_S, 8));
      exp_a.push_back(ev(K_D, 10));
      repeat (30) @(negedge clk);
      row_end();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
